// File: rtl/alu32_bit_if.sv
// alu32_bit_if: operand/opcode/result bundle for the execute-stage ALU.
// The master side drives the opcode and operands and observes the
// registered result; the slave side is the ALU itself.
interface alu32_bit_if;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;

    modport master (
        output ALUControl,
        output A,
        output B,
        input  ALUResult,
        input  Zero
    );

    modport slave (
        input  ALUControl,
        input  A,
        input  B,
        output ALUResult,
        output Zero
    );
endinterface

// File: rtl/alu32_bit.sv
// alu32_bit: registered 32-bit integer ALU for the MIPS-style execute stage.
// One operation per clock, selected by a 6-bit code; the result and a zero
// flag are registered together with one cycle of latency.
// Optional feature: define ALU_MUL_EN to compile in the 32x32 multiplier
// (opcode 011000 -> low 32 bits of the signed product). Without it that
// opcode falls into the undefined-encoding path and yields 0.
// Reset is synchronous and active-low; it clears the result and sets Zero.
module alu32_bit (
    input  logic          Clk,
    input  logic          Rst_n,
    alu32_bit_if.slave    bus
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_MUL  = 6'b011000;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLL  = 6'b000100;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;

    logic [31:0] alu_result_d;
    logic [31:0] alu_result_q;
    logic        zero_d;
    logic        zero_q;

    logic [4:0]  shamt;
    logic        slt_bit;
    logic        sltu_bit;

`ifdef ALU_MUL_EN
    logic [31:0] mul_lo;

    // Low half of a signed product matches the low half of the unsigned one,
    // so a 32-bit context product is sufficient.
    always_comb begin
        mul_lo = 32'($signed(bus.A) * $signed(bus.B));
    end
`endif

    // Operand-derived helpers: only the low five bits of B steer the shifter.
    always_comb begin
        shamt    = bus.B[4:0];
        slt_bit  = ($signed(bus.A) < $signed(bus.B));
        sltu_bit = (bus.A < bus.B);
    end

    // Opcode decode and result selection; undefined codes fall through to 0.
    always_comb begin
        alu_result_d = 32'h0000_0000;
        unique case (bus.ALUControl)
            OP_ADD:  alu_result_d = bus.A + bus.B;
            OP_SUB:  alu_result_d = bus.A - bus.B;
`ifdef ALU_MUL_EN
            OP_MUL:  alu_result_d = mul_lo;
`endif
            OP_AND:  alu_result_d = bus.A & bus.B;
            OP_OR:   alu_result_d = bus.A | bus.B;
            OP_XOR:  alu_result_d = bus.A ^ bus.B;
            OP_NOR:  alu_result_d = ~(bus.A | bus.B);
            OP_SLL:  alu_result_d = bus.A << shamt;
            OP_SRL:  alu_result_d = bus.A >> shamt;
            OP_SRA:  alu_result_d = 32'($signed(bus.A) >>> shamt);
            OP_SLT:  alu_result_d = {31'b0, slt_bit};
            OP_SLTU: alu_result_d = {31'b0, sltu_bit};
            default: alu_result_d = 32'h0000_0000;
        endcase
    end

    // Zero flag derived from the exact value about to be registered.
    always_comb begin
        zero_d = (alu_result_d == 32'h0000_0000);
    end

    // Output register; reset wins over any operation in flight.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            alu_result_q <= 32'h0000_0000;
            zero_q       <= 1'b1;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.ALUResult = alu_result_q;
    assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_alu32_bit.sv
// tb_alu32_bit: directed bench for alu32_bit using an expected-value queue.
module tb_alu32_bit;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_MUL  = 6'b011000;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLL  = 6'b000100;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    alu32_bit_if bus ();

    alu32_bit u_dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_res(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s result: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s zero: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one operation at the falling edge, queue its expectation, and
    // compare just after the next rising edge.
    task automatic step(input logic rst, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n          = rst;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        sb.push_back('{er, (er == 32'h0), tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_res(e.tag, bus.ALUResult, e.res);
        check_zero(e.tag, bus.Zero, e.zero);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ALUControl = OP_ADD;
        bus.A = 32'hFFFF_FFFF;
        bus.B = 32'h1;

        step(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, "rst_edge1");
        step(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, "rst_edge2");
        step(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, "add_wrap");

        step(1'b1, OP_ADD, 32'hA, 32'h5, 32'hF, "add");
        step(1'b1, OP_SUB, 32'hA, 32'h5, 32'h5, "sub");
`ifdef ALU_MUL_EN
        step(1'b1, OP_MUL, 32'hA, 32'h5, 32'h32, "mul");
        step(1'b1, OP_MUL, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, "mul_neg");
`else
        step(1'b1, OP_MUL, 32'hA, 32'h5, 32'h0, "mul_off");
`endif
        step(1'b1, OP_SUB, 32'h5, 32'h5, 32'h0, "sub_eq");
        step(1'b1, OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, "sub_wrap");

        step(1'b1, OP_AND, 32'hA, 32'h5, 32'h0, "and");
        step(1'b1, OP_OR,  32'hA, 32'h5, 32'hF, "or");
        step(1'b1, OP_XOR, 32'hA, 32'h5, 32'hF, "xor");
        step(1'b1, OP_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, "xor2");
        step(1'b1, OP_NOR, 32'hA, 32'h5, 32'hFFFF_FFF0, "nor");

        step(1'b1, OP_SLL, 32'h1, 32'h2, 32'h4, "sll");
        step(1'b1, OP_SRL, 32'h4, 32'h1, 32'h2, "srl");
        step(1'b1, OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, "srl_msb");
        step(1'b1, OP_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, "sra");
        step(1'b1, OP_SRA, 32'h4000_0000, 32'h4, 32'h0400_0000, "sra_pos");
        step(1'b1, OP_SLL, 32'h1, 32'h21, 32'h2, "sll_b21");
        step(1'b1, OP_SLL, 32'h1234_5678, 32'h0, 32'h1234_5678, "sll_zero");
        step(1'b1, OP_SRA, 32'h8765_4321, 32'h20, 32'h8765_4321, "sra_b20");

        step(1'b1, OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, "slt");
        step(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu");
        step(1'b1, OP_SLT,  32'h1, 32'hFFFF_FFFF, 32'h0, "slt_rev");
        step(1'b1, OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, "sltu_rev");

        step(1'b1, 6'b111111, 32'hA, 32'h5, 32'h0, "undef");
        step(1'b1, 6'b000001, 32'hA, 32'h5, 32'h0, "undef2");

        // Outputs must hold while inputs change between edges.
        step(1'b1, OP_OR, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, "hold_pre");
        bus.ALUControl = OP_AND;
        bus.A          = 32'h0;
        bus.B          = 32'h0;
        #2;
        check_res("hold", bus.ALUResult, 32'h1200_0034);
        check_zero("hold", bus.Zero, 1'b0);

        // Mid-stream reset discards the in-flight result.
        step(1'b0, OP_ADD, 32'h10, 32'h20, 32'h0, "rst_mid");
        step(1'b1, OP_ADD, 32'h10, 32'h20, 32'h30, "post_rst");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_empty: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu32_bit.md
# alu32_bit

Registered 32-bit integer ALU for the ECE369 MIPS-style datapath, sitting in the execute stage between the operand muxes and the EX/MEM pipeline register. Each clock it evaluates one operation, selected by a 6-bit `ALUControl` code, on operands `A` and `B`. It registers the 32-bit result together with a zero flag. The block is purely combinational up to a single output register stage.

## Interface

Clocking: one clock; reset is synchronous and active-low.

Parameters:
- None.

Ports:
- `Clk`  input  1  system clock; all state updates on rising edge.
- `Rst_n`  input  1  synchronous, active-low reset.
- `ALUControl`  input  6  operation select; encodings are listed under Operation.
- `A`  input  32  first operand; the value that is shifted for shift operations.
- `B`  input  32  second operand; `B[4:0]` is the shift amount.
- `ALUResult`  output  32  registered result.
- `Zero`  output  1  registered; 1 exactly when the registered `ALUResult` is 0.

## Operation

Operation encodings:
- `000000` ADD: A + B. Modulo 2^32, no overflow flag.
- `100010` SUB: A − B. Modulo 2^32.
- `011000` MUL: low 32 bits of signed A × B. Only when `ALU_MUL_EN` is defined.
- `100100` AND: A & B.
- `100101` OR: A | B.
- `100110` XOR: A ^ B.
- `100111` NOR: ~(A | B).
- `000100` SLL: A << B[4:0]. Zero fill.
- `000010` SRL: A >> B[4:0]. Zero fill.
- `000011` SRA: A >>> B[4:0]. Sign fill from A[31].
- `101010` SLT: 1 if signed A < signed B, else 0.
- `101011` SLTU: 1 if unsigned A < unsigned B, else 0.

Rules:
- Any other encoding yields result 0 and therefore `Zero`=1.
- Shift amounts use only `B[4:0]`; `B[31:5]` is ignored. For example, B=0x21 shifts by 1.
- Shift by 0 passes A through unchanged.
- SLT and SLTU results are zero-extended to 32 bits.
- `Zero` is computed from the same next-state value that is loaded into `ALUResult`, so the two outputs are always consistent.

## Timing

- Latency is 1 cycle. Inputs sampled at rising edge N appear on `ALUResult`/`Zero` after edge N.
- The ALU accepts a new operation every cycle. There is no handshake and no stall input.
- Reset takes priority: if `Rst_n`=0 at a rising edge, `ALUResult` becomes 0x00000000 and `Zero` becomes 1, regardless of the other inputs.
- Reset asserted mid-stream discards the in-flight result. The first valid result appears one cycle after the first edge with `Rst_n`=1.
- Outputs hold their value between edges. Input glitches between edges have no effect on the outputs.

## Configuration

- `ALU_MUL_EN` defined: the 32×32 multiplier is compiled in, and code `011000` returns the low 32 bits of the signed product.
- `ALU_MUL_EN` undefined: no multiplier logic is generated. Code `011000` is treated as an undefined encoding, giving result 0 and `Zero`=1.

## Test plan

- Reset: `Rst_n`=0 for 2 edges with A=0xFFFFFFFF, B=1, ADD → `ALUResult`=0, `Zero`=1. Release reset → one edge later `ALUResult`=0x00000000, `Zero`=1 (wrap-around).
- Arithmetic with A=0xA, B=0x5, one op per cycle:
  - ADD → 0xF
  - SUB → 0x5
  - MUL → 0x32 (when `ALU_MUL_EN`)
  - SUB with A=B=0x5 → 0, `Zero`=1
- Logic with A=0xA, B=0x5:
  - AND → 0x0, `Zero`=1
  - OR → 0xF
  - XOR → 0xF
  - NOR → 0xFFFFFFF0
- Shifts:
  - SLL A=1, B=2 → 0x4
  - SRL A=4, B=1 → 0x2
  - SRA A=0x80000000, B=4 → 0xF8000000
  - SLL A=1, B=0x21 → 0x2
- Compares with A=0xFFFFFFFF, B=1:
  - SLT → 1
  - SLTU → 0
- Undefined code `111111` → 0, `Zero`=1. Without `ALU_MUL_EN`, MUL with A=0xA, B=0x5 → 0, `Zero`=1.
